// File: rtl/serial_add_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_add_pkg
// Description : Shared state encoding and counter sizing for serial_add_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    // Bit-position counter needs at least one bit even for a 1-bit adder.
    function automatic int cnt_width(input int w);
        return (w <= 1) ? 1 : $clog2(w);
    endfunction

endpackage
`default_nettype wire

// File: rtl/serial_add_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : serial_add_ctrl_if
// Description : Start/busy/done request and result bundle for the serial adder.
// Revision    : 1.0 - initial release
// ============================================================================
interface serial_add_ctrl_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout
    );
endinterface
`default_nettype wire

// File: rtl/serial_add_ctrl_fa.sv
`default_nettype none
// ============================================================================
// Module      : serial_add_ctrl_fa
// Description : 1-bit full adder used as the shared serial datapath.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_add_ctrl_fa (
    input  wire logic a,
    input  wire logic b,
    input  wire logic cin,
    output logic      s,
    output logic      cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule
`default_nettype wire

// File: rtl/serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : serial_add_ctrl
// Description : Bit-serial adder controller, LSB first, one FA over WIDTH cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  wire logic         clk,
    input  wire logic         rst,
    serial_add_ctrl_if.slave  bus
);
    localparam int               c_cnt_w    = cnt_width(WIDTH);
    localparam logic [c_cnt_w-1:0] c_last_cnt = c_cnt_w'(WIDTH - 1);

    state_t             r_state;
    state_t             w_state_next;
    logic [WIDTH-1:0]   r_a_sr;
    logic [WIDTH-1:0]   r_b_sr;
    logic               r_c;
    logic [c_cnt_w-1:0] r_cnt;
    logic [WIDTH-1:0]   r_sum;
    logic               r_cout;
    logic               w_s;
    logic               w_co;
    logic [WIDTH-1:0]   w_acc_next;
    logic               w_last;

    serial_add_ctrl_fa u_fa (
        .a    (r_a_sr[0]),
        .b    (r_b_sr[0]),
        .cin  (r_c),
        .s    (w_s),
        .cout (w_co)
    );

    assign w_last = (r_cnt == c_last_cnt);

    // Accumulator bit 0 is always shifted out, so only the upper bits are stored.
    generate
        if (WIDTH == 1) begin : g_narrow
            assign w_acc_next = w_s;
        end else begin : g_wide
            logic [WIDTH-2:0] r_acc;
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_acc <= '0;
                end else if (r_state == RUN) begin
                    r_acc <= w_acc_next[WIDTH-1:1];
                end
            end
            assign w_acc_next = {w_s, r_acc};
        end
    endgenerate

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (bus.start) w_state_next = RUN;
            RUN:     if (w_last)    w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_a_sr  <= '0;
            r_b_sr  <= '0;
            r_c     <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_a_sr <= bus.a;
                        r_b_sr <= bus.b;
                        r_c    <= bus.cin;
                        r_cnt  <= '0;
                    end
                end
                RUN: begin
                    r_a_sr <= r_a_sr >> 1;
                    r_b_sr <= r_b_sr >> 1;
                    r_c    <= w_co;
                    r_cnt  <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_sum  <= w_acc_next;
                        r_cout <= w_co;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = (r_state == RUN);
    assign bus.done = (r_state == DONE);
    assign bus.sum  = r_sum;
    assign bus.cout = r_cout;

endmodule
`default_nettype wire

// File: tb/tb_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_add_ctrl
// Description : Self-checking bench for serial_add_ctrl against a timeline model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_add_ctrl;
    localparam int WIDTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    serial_add_ctrl_if #(.WIDTH(WIDTH)) bus ();
    serial_add_ctrl_if #(.WIDTH(1))     bus1 ();

    serial_add_ctrl #(.WIDTH(WIDTH)) dut  (.clk(clk), .rst(rst), .bus(bus));
    serial_add_ctrl #(.WIDTH(1))     dut1 (.clk(clk), .rst(rst), .bus(bus1));

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Timeline model: an accepted request yields busy for WIDTH cycles, then done with a+b+cin.
    int               m_left = 0;
    bit               m_done = 1'b0;
    logic [WIDTH-1:0] m_sum  = '0;
    logic             m_cout = 1'b0;
    logic [WIDTH:0]   m_pend = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_left = 0;
            m_done = 1'b0;
            m_sum  = '0;
            m_cout = 1'b0;
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (m_left > 0) begin
            m_left = m_left - 1;
            if (m_left == 0) begin
                m_done = 1'b1;
                {m_cout, m_sum} = m_pend;
            end
        end else if (bus.start) begin
            m_left = WIDTH;
            m_pend = {1'b0, bus.a} + {1'b0, bus.b} + (WIDTH+1)'(bus.cin);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", 32'(bus.busy), 32'(m_left > 0));
            check("done", 32'(bus.done), 32'(m_done));
            check("sum",  32'(bus.sum),  32'(m_sum));
            check("cout", 32'(bus.cout), 32'(m_cout));
        end
    end

    // Single request with literal/arithmetic expectation; operands scrambled while running.
    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic cin,
                          input logic [WIDTH-1:0] exp_sum, input logic exp_cout, input string name);
        int bc = 0;
        int guard = 0;
        bus.start = 1'b1; bus.a = a; bus.b = b; bus.cin = cin;
        @(negedge clk);
        bus.start = 1'b0;
        while (!bus.done && guard < WIDTH + 4) begin
            if (bus.busy) bc++;
            bus.a   = WIDTH'($urandom);
            bus.b   = WIDTH'($urandom);
            bus.cin = 1'($urandom);
            @(negedge clk);
            guard++;
        end
        check({name, "_done_seen"}, 32'(bus.done), 32'd1);
        check({name, "_busy_cycles"}, 32'(bc), 32'(WIDTH));
        check({name, "_sum"}, 32'(bus.sum), 32'(exp_sum));
        check({name, "_cout"}, 32'(bus.cout), 32'(exp_cout));
        @(negedge clk);
    endtask

    initial begin
        logic [WIDTH:0] tot;
        int last_done;
        int i_rst;
        bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
        bus1.start = 1'b0; bus1.a = '0; bus1.b = '0; bus1.cin = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_sum",  32'(bus.sum),  32'd0);
        check("rst_cout", 32'(bus.cout), 32'd0);
        check("rst1_sum", 32'(bus1.sum), 32'd0);
        chk_en = 1'b1;

        run_op(4'b0011, 4'b0101, 1'b0, 4'b1000, 1'b0, "t1");
        run_op(4'b1111, 4'b0001, 1'b0, 4'b0000, 1'b1, "t2_wrap");
        run_op(4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b1, "t2_max");

        // Abort on the second RUN cycle.
        bus.start = 1'b1; bus.a = 4'b0011; bus.b = 4'b0101; bus.cin = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        check("abort_sum",  32'(bus.sum),  32'd0);
        check("abort_cout", 32'(bus.cout), 32'd0);
        repeat (WIDTH + 2) begin
            @(negedge clk);
            check("abort_no_done", 32'(bus.done), 32'd0);
        end
        run_op(4'b0110, 4'b0001, 1'b0, 4'b0111, 1'b0, "t4_after");

        // Held start: back-to-back operations at WIDTH+2 spacing.
        last_done = -1;
        bus.start = 1'b1;
        for (int c = 0; c < 40; c++) begin
            bus.a   = WIDTH'($urandom);
            bus.b   = WIDTH'($urandom);
            bus.cin = 1'($urandom);
            @(negedge clk);
            if (bus.done) begin
                if (last_done >= 0) check("held_spacing", 32'(c - last_done), 32'(WIDTH + 2));
                last_done = c;
            end
        end
        bus.start = 1'b0;
        repeat (WIDTH + 2) @(negedge clk);

        for (int i = 0; i < 512; i++) begin
            tot = {1'b0, 4'(i)} + {1'b0, 4'(i >> 4)} + 5'(i >> 8);
            run_op(4'(i), 4'(i >> 4), 1'(i >> 8), tot[WIDTH-1:0], tot[WIDTH], "exh");
        end

        // Random requests with occasional reset at arbitrary phases.
        for (int c = 0; c < 300; c++) begin
            i_rst     = int'($urandom_range(0, 19));
            rst       = (i_rst == 0);
            bus.start = 1'($urandom);
            bus.a     = WIDTH'($urandom);
            bus.b     = WIDTH'($urandom);
            bus.cin   = 1'($urandom);
            @(negedge clk);
        end
        rst = 1'b0;
        bus.start = 1'b0;
        repeat (WIDTH + 3) @(negedge clk);

        // One-bit instance.
        bus1.start = 1'b1; bus1.a = 1'b1; bus1.b = 1'b1; bus1.cin = 1'b1;
        @(negedge clk);
        bus1.start = 1'b0;
        check("w1_busy", 32'(bus1.busy), 32'd1);
        check("w1_done_early", 32'(bus1.done), 32'd0);
        @(negedge clk);
        check("w1_busy_off", 32'(bus1.busy), 32'd0);
        check("w1_done", 32'(bus1.done), 32'd1);
        check("w1_sum",  32'(bus1.sum),  32'd1);
        check("w1_cout", 32'(bus1.cout), 32'd1);
        @(negedge clk);
        check("w1_done_pulse", 32'(bus1.done), 32'd0);
        check("w1_sum_hold", 32'(bus1.sum), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        n_tests++;
        n_fail++;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
